pic_ctrl: RTL and testbench

- Priority interrupt controller: the requesting end of the CPU interrupt entry/return sequencer.
- Collects device interrupt requests, latches them as pending, and arbitrates by per-source programmable priority.
- Presents the winning request on pic_out in the format the sequencer consumes: [7] valid, [6:4] priority, [3:0] vector.
- Freezes its offer while the CPU is entering a handler, then retires the serviced source on acknowledge.

---
 rtl/pic_pkg.sv | 38 +++
 rtl/pic_ctrl_prio_arbiter.sv | 31 +++
 rtl/pic_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pic_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the priority interrupt controller.
// Defines the pic_out field layout, the FSM encoding, the field widths and a
// helper that packs an offer word.
package pic_pkg;

  localparam int unsigned PRI_W     = 3;
  localparam int unsigned VECT_W    = 4;
  localparam int unsigned PIC_W     = 8;
  localparam int unsigned VALID_BIT = 7;
  localparam int unsigned PRI_MSB   = 6;
  localparam int unsigned PRI_LSB   = 4;
  localparam int unsigned VECT_MSB  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    LOCK   = 2'd2,
    RETIRE = 2'd3
  } pic_state_e;

  // Word presented to the entry/return sequencer.
  typedef struct packed {
    logic                   valid;
    logic [PRI_MSB:PRI_LSB] pri;
    logic [VECT_MSB:0]      vect;
  } pic_word_t;

  function automatic logic [PIC_W-1:0] pack_offer(input logic              valid,
                                                  input logic [PRI_W-1:0]  pri,
                                                  input logic [VECT_W-1:0] vect);
    pic_word_t w;
    w.valid = valid;
    w.pri   = pri;
    w.vect  = vect;
    return w;
  endfunction

endpackage

// File: rtl/pic_ctrl_prio_arbiter.sv
// Combinational priority arbiter.
// Ports: cand - candidate mask; pri - packed per-source priorities (PRI_W each);
//        any - some candidate present; win_idx/win_pri - winning source and its
//        priority. Highest priority wins, a tie goes to the lowest index.
module pic_prio_arbiter
  import pic_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]       cand,
  input  logic [NUM_SRC*PRI_W-1:0] pri,
  output logic                     any,
  output logic [2:0]               win_idx,
  output logic [PRI_W-1:0]         win_pri
);

  // Ascending scan with a strict compare keeps the lowest index on ties.
  always_comb begin
    any     = 1'b0;
    win_idx = 3'd0;
    win_pri = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (!any || (pri[i*PRI_W +: PRI_W] > win_pri))) begin
        any     = 1'b1;
        win_idx = 3'(i);
        win_pri = pri[i*PRI_W +: PRI_W];
      end
    end
  end

endmodule

// File: rtl/pic_ctrl.sv
// Priority interrupt controller: requesting end of the CPU interrupt
// entry/return sequencer.
// Ports: clk/rst (sync, active high); irq_in async requests (rising edge);
//        cfg_we/cfg_idx/cfg_pri/cfg_en source config write; cfg_clr_ovf clears
//        ovf of cfg_idx; cpu_pri current CPU priority; iv_lock/iv_ack entry
//        handshake; pic_out {valid,pri,vect}; irq_req offer beats cpu_pri;
//        pend_out pending bits; ovf_out sticky lost-request flags.
module pic_ctrl
  import pic_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned VECT_BASE   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [PRI_W-1:0]   cfg_pri,
  input  logic               cfg_en,
  input  logic               cfg_clr_ovf,
  input  logic [PRI_W-1:0]   cpu_pri,
  input  logic               iv_lock,
  input  logic               iv_ack,
  output logic [PIC_W-1:0]   pic_out,
  output logic               irq_req,
  output logic [NUM_SRC-1:0] pend_out,
  output logic [NUM_SRC-1:0] ovf_out
);

  logic [NUM_SRC-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]       hist_q;
  logic [NUM_SRC-1:0]       rise;
  logic [NUM_SRC-1:0]       pend_q;
  logic [NUM_SRC-1:0]       ovf_q;
  logic [NUM_SRC-1:0]       en_q;
  logic [PRI_W-1:0]         pri_q [NUM_SRC];
  logic [NUM_SRC*PRI_W-1:0] pri_flat;
  logic [NUM_SRC-1:0]       ack_clr;
  logic [NUM_SRC-1:0]       ovf_clr;

  pic_state_e         state_q, state_d;
  logic [PIC_W-1:0]   pic_q, pic_d;
  logic               irq_q, irq_d;
  logic [2:0]         off_idx_q, off_idx_d;
  logic [2:0]         lock_idx_q, lock_idx_d;
  logic               ack_fire;

  logic               any;
  logic [2:0]         win_idx;
  logic [PRI_W-1:0]   win_pri;
  logic [VECT_W-1:0]  win_vect;
  logic [PIC_W-1:0]   win_word;

  // Request synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Per-source config; indices outside the source range never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) pri_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_we && (cfg_idx == 3'(i))) begin
          pri_q[i] <= cfg_pri;
          en_q[i]  <= cfg_en;
        end
      end
    end
  end

  // Clear masks for the serviced source and the overflow clear request.
  always_comb begin
    ack_clr  = '0;
    ovf_clr  = '0;
    pri_flat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i]                  = ack_fire && (lock_idx_q == 3'(i));
      ovf_clr[i]                  = cfg_clr_ovf && (cfg_idx == 3'(i));
      pri_flat[i*PRI_W +: PRI_W]  = pri_q[i];
    end
  end

  // Pending/overflow: a new edge beats both the ack clear and the ovf clear;
  // an edge coinciding with the ack of its own source is not a lost request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~ack_clr) | rise;
      ovf_q  <= (ovf_q & ~ovf_clr) | (rise & pend_q & ~ack_clr);
    end
  end

  pic_prio_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .cand    (pend_q & en_q),
    .pri     (pri_flat),
    .any     (any),
    .win_idx (win_idx),
    .win_pri (win_pri)
  );

  assign win_vect = VECT_W'(VECT_BASE + 32'(win_idx));
  assign win_word = pack_offer(any, win_pri, win_vect);

  // Offer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pic_q      <= '0;
      irq_q      <= 1'b0;
      off_idx_q  <= 3'd0;
      lock_idx_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      pic_q      <= pic_d;
      irq_q      <= irq_d;
      off_idx_q  <= off_idx_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Next state and next offer; LOCK holds the frozen word.
  always_comb begin
    state_d    = state_q;
    pic_d      = pic_q;
    off_idx_d  = off_idx_q;
    lock_idx_d = lock_idx_q;
    ack_fire   = 1'b0;
    case (state_q)
      IDLE, RETIRE: begin
        if (any) begin
          state_d   = OFFER;
          pic_d     = win_word;
          off_idx_d = win_idx;
        end else begin
          state_d = IDLE;
          pic_d   = '0;
        end
      end
      OFFER: begin
        if (iv_lock && pic_q[VALID_BIT]) begin
          state_d    = LOCK;
          lock_idx_d = off_idx_q;
        end else if (!any) begin
          state_d = IDLE;
          pic_d   = '0;
        end else begin
          pic_d     = win_word;
          off_idx_d = win_idx;
        end
      end
      LOCK: begin
        if (iv_ack) begin
          ack_fire = 1'b1;
          state_d  = RETIRE;
          pic_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pic_d   = '0;
      end
    endcase
    irq_d = (state_d == OFFER) && pic_d[VALID_BIT] && (pic_d[PRI_MSB:PRI_LSB] > cpu_pri);
  end

  assign pic_out  = pic_q;
  assign irq_req  = irq_q;
  assign pend_out = pend_q;
  assign ovf_out  = ovf_q;

endmodule

// File: tb/tb_pic_ctrl.sv
// Self-checking bench for pic_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of the controller.
module tb_pic_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned VB = 8;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_in = '0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_idx = '0;
  logic [2:0]   cfg_pri = '0;
  logic         cfg_en = 1'b0;
  logic         cfg_clr_ovf = 1'b0;
  logic [2:0]   cpu_pri = '0;
  logic         iv_lock = 1'b0;
  logic         iv_ack = 1'b0;
  logic [7:0]   pic_out;
  logic         irq_req;
  logic [N-1:0] pend_out;
  logic [N-1:0] ovf_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pic_ctrl #(.NUM_SRC(N), .VECT_BASE(VB), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_pri     (cfg_pri),
    .cfg_en      (cfg_en),
    .cfg_clr_ovf (cfg_clr_ovf),
    .cpu_pri     (cpu_pri),
    .iv_lock     (iv_lock),
    .iv_ack      (iv_ack),
    .pic_out     (pic_out),
    .irq_req     (irq_req),
    .pend_out    (pend_out),
    .ovf_out     (ovf_out)
  );

  // Behavioural model state.
  bit [N-1:0] m_pend, m_ovf, m_en;
  bit [2:0]   m_pri [N];
  bit [7:0]   m_pic;
  bit         m_irq, m_locked, m_retire, m_live;
  int         m_off_idx, m_lock_idx;
  bit [N-1:0] smp [SS+1];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model, evaluated on the inputs the DUT samples.
  task automatic model_step();
    bit [N-1:0] rise, cand, ackclr, clr;
    bit         w_ok;
    int         w_i;
    if (rst) begin
      m_pend = '0; m_ovf = '0; m_en = '0; m_pic = '0; m_irq = 0;
      m_locked = 0; m_retire = 0; m_off_idx = 0; m_lock_idx = 0;
      for (int i = 0; i < N; i++) m_pri[i] = '0;
      for (int k = 0; k <= SS; k++) smp[k] = '0;
      m_live = 1;
      return;
    end
    // Request appears SS edges after first sampled high, relative to the sample before it.
    rise = smp[SS-1] & ~smp[SS];
    for (int k = SS; k >= 1; k--) smp[k] = smp[k-1];
    smp[0] = irq_in;
    cand = m_pend & m_en;
    w_ok = 0; w_i = 0;
    for (int p = 7; p >= 0; p--)
      for (int i = 0; i < N; i++)
        if (!w_ok && cand[i] && m_pri[i] == 3'(p)) begin w_ok = 1; w_i = i; end
    ackclr = '0;
    if (m_locked) begin
      if (iv_ack) begin
        ackclr[m_lock_idx] = 1'b1;
        m_locked = 0; m_retire = 1; m_pic = '0;
      end
    end else if (!m_retire && m_pic[7] && iv_lock) begin
      m_locked = 1; m_lock_idx = m_off_idx;
    end else begin
      m_retire = 0;
      if (w_ok) begin
        m_pic = {1'b1, m_pri[w_i], 4'((VB + w_i) % 16)};
        m_off_idx = w_i;
      end else m_pic = '0;
    end
    m_irq = !m_locked && m_pic[7] && (m_pic[6:4] > cpu_pri);
    clr = '0;
    if (cfg_clr_ovf && cfg_idx < N) clr[cfg_idx] = 1'b1;
    m_ovf  = (m_ovf & ~clr) | (rise & m_pend & ~ackclr);
    m_pend = (m_pend & ~ackclr) | rise;
    if (cfg_we && cfg_idx < N) begin
      m_pri[cfg_idx] = cfg_pri;
      m_en[cfg_idx]  = cfg_en;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("model_pic_out", pic_out, m_pic);
      chk("model_irq_req", 8'(irq_req), 8'(m_irq));
      chk("model_pend", pend_out, m_pend);
      chk("model_ovf", ovf_out, m_ovf);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int idx, input int pri, input bit en);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_pri = 3'(pri); cfg_en = en;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = m;
    step(1);
    irq_in = '0;
  endtask

  task automatic service();
    iv_lock = 1'b1; step(1);
    iv_lock = 1'b0; iv_ack = 1'b1; step(1);
    iv_ack = 1'b0; step(1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_pic", pic_out, 8'h00);
    chk("rst_irq", 8'(irq_req), 8'h00);
    chk("rst_pend", pend_out, 8'h00);
    chk("rst_ovf", ovf_out, 8'h00);

    // Single source latency and irq_req against cpu_pri.
    cfg_write(3, 5, 1'b1);
    cpu_pri = 3'd2;
    pulse(8'h08);                         // edge 0
    step(1); chk("t1_pend_e1", pend_out, 8'h00);
    step(1); chk("t1_pend_e2", pend_out, 8'h08); chk("t1_pic_e2", pic_out, 8'h00);
    step(1); chk("t1_pic_e3", pic_out, 8'hDB); chk("t1_irq_hi", 8'(irq_req), 8'h01);
    cpu_pri = 3'd5;
    step(1); chk("t1_irq_lo", 8'(irq_req), 8'h00); chk("t1_pic_keep", pic_out, 8'hDB);
    service();
    chk("t1_pend_done", pend_out, 8'h00);

    // Priority tie goes to the lower index.
    cpu_pri = 3'd0;
    cfg_write(1, 4, 1'b1);
    cfg_write(6, 4, 1'b1);
    pulse(8'h42);
    step(3); chk("t2_tie", pic_out, 8'hC9); chk("t2_irq", 8'(irq_req), 8'h01);
    iv_lock = 1'b1; step(1); iv_lock = 1'b0;
    chk("t2_lock", pic_out, 8'hC9); chk("t2_lock_irq", 8'(irq_req), 8'h00);
    iv_ack = 1'b1; step(1); iv_ack = 1'b0;
    chk("t2_retire", pic_out, 8'h00);
    step(1); chk("t2_next", pic_out, 8'hCE);
    service();

    // Frozen offer in LOCK while a higher-priority request arrives.
    cfg_write(2, 3, 1'b1);
    cfg_write(7, 7, 1'b1);
    pulse(8'h04);
    step(3); chk("t3_offer", pic_out, 8'hBA);
    iv_lock = 1'b1; step(1); iv_lock = 1'b0;
    pulse(8'h80);
    step(3); chk("t3_frozen", pic_out, 8'hBA); chk("t3_pend", pend_out, 8'h84);
    iv_ack = 1'b1; step(1); iv_ack = 1'b0;
    chk("t3_retire", pic_out, 8'h00);
    step(1); chk("t3_preempt", pic_out, 8'hFF);
    service();

    // Overflow set, clear, and clear colliding with a new edge.
    pulse(8'h01);
    step(1);
    pulse(8'h01);
    step(3); chk("t4_ovf_set", ovf_out, 8'h01); chk("t4_pend", pend_out, 8'h01);
    chk("t4_no_offer", pic_out, 8'h00);
    cfg_clr_ovf = 1'b1; cfg_idx = 3'd0; step(1); cfg_clr_ovf = 1'b0;
    chk("t4_ovf_clr", ovf_out, 8'h00);
    pulse(8'h01);                         // edge k
    step(1);                              // edge k+1
    cfg_clr_ovf = 1'b1; cfg_idx = 3'd0; step(1); cfg_clr_ovf = 1'b0;
    chk("t4_ovf_clr_vs_set", ovf_out, 8'h01);

    // Disable/re-enable a pending source.
    cfg_write(4, 2, 1'b1);
    pulse(8'h10);
    step(3); chk("t5_offer", pic_out, 8'hAC);
    cfg_write(4, 2, 1'b0);
    step(1); chk("t5_dis_pic", pic_out, 8'h00); chk("t5_dis_pend", pend_out, 8'h11);
    cfg_write(4, 2, 1'b1);
    step(1); chk("t5_reen", pic_out, 8'hAC);

    // Reset during LOCK, then a stray ack.
    iv_lock = 1'b1; step(1); iv_lock = 1'b0;
    chk("t6_lock", pic_out, 8'hAC);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t6_rst_pic", pic_out, 8'h00); chk("t6_rst_irq", 8'(irq_req), 8'h00);
    chk("t6_rst_pend", pend_out, 8'h00); chk("t6_rst_ovf", ovf_out, 8'h00);
    iv_ack = 1'b1; step(1); iv_ack = 1'b0;
    chk("t6_ack_pic", pic_out, 8'h00); chk("t6_ack_pend", pend_out, 8'h00);

    // Randomized traffic checked by the model only.
    for (int c = 0; c < 3000; c++) begin
      irq_in      = irq_in ^ N'($urandom & $urandom & $urandom);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_idx     = 3'($urandom);
      cfg_pri     = 3'($urandom);
      cfg_en      = ($urandom_range(0, 3) != 0);
      cfg_clr_ovf = ($urandom_range(0, 15) == 0);
      cpu_pri     = 3'($urandom);
      iv_lock     = ($urandom_range(0, 3) == 0);
      iv_ack      = ($urandom_range(0, 3) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0; cfg_we = 1'b0; cfg_clr_ovf = 1'b0; iv_lock = 1'b0; iv_ack = 1'b0;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
